// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 constants, round helpers and scanner state encoding
package sha256_pkg;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] CH0 = 32'h6a09e667;
  localparam logic [31:0] CH1 = 32'hbb67ae85;
  localparam logic [31:0] CH2 = 32'h3c6ef372;
  localparam logic [31:0] CH3 = 32'ha54ff53a;
  localparam logic [31:0] CH4 = 32'h510e527f;
  localparam logic [31:0] CH5 = 32'h9b05688c;
  localparam logic [31:0] CH6 = 32'h1f83d9ab;
  localparam logic [31:0] CH7 = 32'h5be0cd19;
  localparam logic [255:0] IV = {CH0, CH1, CH2, CH3, CH4, CH5, CH6, CH7};

  localparam logic [31:0] PAD_WORD = 32'h80000000;
  localparam logic [31:0] LEN_640  = 32'h00000280;
  localparam logic [31:0] LEN_256  = 32'h00000100;

  typedef enum logic [2:0] {ST_IDLE, ST_MID, ST_BLK2, ST_DBL, ST_CMP, ST_FIN} scan_state_t;

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [255:0] byte_rev256(input logic [255:0] x);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = x[255-8*i -: 8];
    return r;
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] w,
                                             input logic [31:0] k);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + bsig1(e) + ((e & f) ^ (~e & g)) + k + w;
    t2 = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

endpackage

// File: rtl/sha256_compress.sv
// rtl/sha256_compress.sv - iterative SHA-256 compression, UNROLL rounds per clock
module sha256_compress import sha256_pkg::*; #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] state_in,
  input  logic [511:0] block_in,
  output logic [255:0] state_out,
  output logic         done
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
    $error("sha256_compress: UNROLL must be 1, 2, 4 or 8");
  end

  logic [255:0] work, hin;
  logic [31:0]  win [0:15];
  logic [5:0]   rnd;
  logic         run, fin;

  logic [255:0] s_chain [0:UNROLL];
  logic [31:0]  w_chain [0:UNROLL][0:15];

  // The window always holds W[t..t+15]; each round shifts in W[t+16].
  always_comb begin
    s_chain[0] = work;
    for (int i = 0; i < 16; i++) w_chain[0][i] = win[i];
    for (int u = 0; u < UNROLL; u++) begin
      s_chain[u+1] = sha_round(s_chain[u], w_chain[u][0], K[rnd + 6'(u)]);
      for (int i = 0; i < 15; i++) w_chain[u+1][i] = w_chain[u][i+1];
      w_chain[u+1][15] = ssig1(w_chain[u][14]) + w_chain[u][9] + ssig0(w_chain[u][1]) + w_chain[u][0];
    end
  end

  always_comb begin
    state_out = '0;
    for (int i = 0; i < 8; i++) state_out[255-32*i -: 32] = hin[255-32*i -: 32] + work[255-32*i -: 32];
  end

  assign done = fin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work <= '0;
      hin  <= '0;
      rnd  <= '0;
      run  <= 1'b0;
      fin  <= 1'b0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else if (start) begin
      work <= state_in;
      hin  <= state_in;
      rnd  <= '0;
      run  <= 1'b1;
      fin  <= 1'b0;
      for (int i = 0; i < 16; i++) win[i] <= block_in[511-32*i -: 32];
    end else if (run) begin
      work <= s_chain[UNROLL];
      for (int i = 0; i < 16; i++) win[i] <= w_chain[UNROLL][i];
      rnd <= rnd + 6'(UNROLL);
      if (rnd == 6'(64 - UNROLL)) begin
        run <= 1'b0;
        fin <= 1'b1;
      end
    end else begin
      fin <= 1'b0;
    end
  end

endmodule

// File: rtl/sha256d_nonce_scanner.sv
// rtl/sha256d_nonce_scanner.sv - double-SHA-256 nonce sweep over a cached midstate
module sha256d_nonce_scanner import sha256_pkg::*; #(
  parameter int UNROLL  = 1,
  parameter bit LE_MODE = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [607:0] header_in,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  input  logic [255:0] target,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic [31:0]  found_nonce,
  output logic [255:0] found_hash,
  output logic [32:0]  nonces_tried
);

  scan_state_t  state, state_n;
  logic [95:0]  hdr_tail;
  logic [31:0]  nonce_cur, nonce_last;
  logic [255:0] tgt, midstate, hash_q;
  logic         abort_seen;
  logic         comp_start, comp_done;
  logic [255:0] comp_state_in, comp_out;
  logic [511:0] comp_block_in;
  logic         hit, stop;

  function automatic logic [511:0] blk2_block(input logic [95:0] tail, input logic [31:0] n);
    return {tail, (LE_MODE ? bswap32(n) : n), PAD_WORD, 320'h0, LEN_640};
  endfunction

  sha256_compress #(.UNROLL(UNROLL)) u_compress (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (comp_start),
    .state_in  (comp_state_in),
    .block_in  (comp_block_in),
    .state_out (comp_out),
    .done      (comp_done)
  );

  assign hit  = (hash_q <= tgt);
  assign stop = hit || (nonce_cur == nonce_last) || abort_seen || abort;
  assign busy = (state != ST_IDLE);
  assign done = (state == ST_FIN);

  // Each phase launches the next compression in its own final cycle, so the
  // core never idles between MID, BLK2 and DBL.
  always_comb begin
    state_n       = state;
    comp_start    = 1'b0;
    comp_state_in = IV;
    comp_block_in = '0;
    case (state)
      ST_IDLE: if (start) begin
        state_n       = ST_MID;
        comp_start    = 1'b1;
        comp_block_in = header_in[607:96];
      end
      ST_MID: if (comp_done) begin
        state_n       = ST_BLK2;
        comp_start    = 1'b1;
        comp_state_in = comp_out;
        comp_block_in = blk2_block(hdr_tail, nonce_cur);
      end
      ST_BLK2: if (comp_done) begin
        state_n       = ST_DBL;
        comp_start    = 1'b1;
        comp_block_in = {comp_out, PAD_WORD, 192'h0, LEN_256};
      end
      ST_DBL: if (comp_done) state_n = ST_CMP;
      ST_CMP: begin
        if (stop) begin
          state_n = ST_FIN;
        end else begin
          state_n       = ST_BLK2;
          comp_start    = 1'b1;
          comp_state_in = midstate;
          comp_block_in = blk2_block(hdr_tail, nonce_cur + 32'd1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      hdr_tail     <= '0;
      nonce_cur    <= '0;
      nonce_last   <= '0;
      tgt          <= '0;
      midstate     <= '0;
      hash_q       <= '0;
      abort_seen   <= 1'b0;
      found        <= 1'b0;
      found_nonce  <= '0;
      found_hash   <= '0;
      nonces_tried <= '0;
    end else begin
      state <= state_n;
      case (state)
        ST_IDLE: if (start) begin
          hdr_tail     <= header_in[95:0];
          nonce_cur    <= nonce_start;
          nonce_last   <= nonce_end;
          tgt          <= target;
          found        <= 1'b0;
          found_nonce  <= '0;
          found_hash   <= '0;
          nonces_tried <= '0;
        end
        ST_MID: if (comp_done) midstate <= comp_out;
        ST_DBL: if (comp_done) hash_q <= LE_MODE ? byte_rev256(comp_out) : comp_out;
        ST_CMP: begin
          nonces_tried <= nonces_tried + 33'd1;
          if (hit) begin
            found       <= 1'b1;
            found_nonce <= nonce_cur;
            found_hash  <= hash_q;
          end
          if (!stop) nonce_cur <= nonce_cur + 32'd1;
        end
        default: ;
      endcase
      if (state == ST_IDLE || state == ST_CMP) abort_seen <= 1'b0;
      else if (abort) abort_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sha256d_nonce_scanner.sv
// tb/tb_sha256d_nonce_scanner.sv - directed bench for the double-SHA-256 nonce scanner
module tb_sha256d_nonce_scanner;

  localparam logic [607:0] GENESIS = {32'h01000000, 256'h0,
    256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
    32'h29ab5f49, 32'hffff001d};
  localparam logic [255:0] GEN_TGT  = {32'h0, 16'hffff, 208'h0};
  localparam logic [255:0] GEN_HASH =
    256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, start_x, abort;
  logic [607:0] header_in;
  logic [31:0]  nonce_start, nonce_end;
  logic [255:0] target;

  logic         busy_v [4];
  logic         done_v [4];
  logic         found_v [4];
  logic [31:0]  fnonce_v [4];
  logic [255:0] fhash_v [4];
  logic [32:0]  tried_v [4];

  int compared = 0;
  int mismatched = 0;
  int exp_cyc [4] = '{591, 303, 159, 87};
  int dcyc [4];
  int cyc;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sha256d_nonce_scanner #(.UNROLL(1 << g), .LE_MODE(1'b1)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (g == 0 ? start : start_x),
      .abort        (g == 0 ? abort : 1'b0),
      .header_in    (header_in),
      .nonce_start  (nonce_start),
      .nonce_end    (nonce_end),
      .target       (target),
      .busy         (busy_v[g]),
      .done         (done_v[g]),
      .found        (found_v[g]),
      .found_nonce  (fnonce_v[g]),
      .found_hash   (fhash_v[g]),
      .nonces_tried (tried_v[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_job(input logic [607:0] h, input logic [31:0] ns, input logic [31:0] ne,
                         input logic [255:0] t);
    header_in = h;
    nonce_start = ns;
    nonce_end = ne;
    target = t;
  endtask

  // cyc counts cycles from the start cycle through the done cycle inclusive.
  task automatic run_u1(input int abort_at, output int cyc_o);
    cyc_o = -1;
    start = 1'b1;
    abort = (abort_at == 0);
    tick();
    start = 1'b0;
    abort = 1'b0;
    for (int k = 1; k <= 3000; k++) begin
      if (done_v[0]) begin
        cyc_o = k;
        break;
      end
      abort = (k == abort_at);
      tick();
    end
    if (cyc_o >= 0) cyc_o = cyc_o + 1;
    abort = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    start_x = 1'b0;
    abort = 1'b0;
    set_job(GENESIS, 32'h0, 32'h0, '0);
    tick();
    tick();
    chk("rst_busy", 256'(busy_v[0]), 256'(0));
    chk("rst_done", 256'(done_v[0]), 256'(0));
    chk("rst_found", 256'(found_v[0]), 256'(0));
    chk("rst_nonce", 256'(fnonce_v[0]), 256'(0));
    chk("rst_hash", fhash_v[0], 256'(0));
    chk("rst_tried", 256'(tried_v[0]), 256'(0));
    rst_n = 1'b1;
    tick();

    // Genesis sweep on all unroll variants, with a start pulse mid-job that must be ignored.
    set_job(GENESIS, 32'h7C2BAC1A, 32'h7C2BAC1F, GEN_TGT);
    for (int g = 0; g < 4; g++) dcyc[g] = -1;
    start = 1'b1;
    start_x = 1'b1;
    tick();
    start = 1'b0;
    start_x = 1'b0;
    for (int k = 1; k <= 1500; k++) begin
      for (int g = 0; g < 4; g++) if (done_v[g] && dcyc[g] < 0) dcyc[g] = k + 1;
      if (dcyc[0] >= 0 && dcyc[1] >= 0 && dcyc[2] >= 0 && dcyc[3] >= 0) break;
      if (k == 40) begin
        start = 1'b1;
        start_x = 1'b1;
        set_job(~GENESIS, 32'd5, 32'd9, '1);
      end else begin
        start = 1'b0;
        start_x = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    start_x = 1'b0;
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("gen_found_u%0d", 1 << g), 256'(found_v[g]), 256'(1));
      chk($sformatf("gen_nonce_u%0d", 1 << g), 256'(fnonce_v[g]), 256'h7C2BAC1D);
      chk($sformatf("gen_tried_u%0d", 1 << g), 256'(tried_v[g]), 256'(4));
      chk($sformatf("gen_hash_u%0d", 1 << g), fhash_v[g], GEN_HASH);
      chk($sformatf("gen_cycles_u%0d", 1 << g), 256'(dcyc[g]), 256'(exp_cyc[g]));
    end
    tick();
    chk("gen_done_pulse", 256'(done_v[0]), 256'(0));
    chk("gen_busy_end", 256'(busy_v[0]), 256'(0));

    // Target all-ones: hit on the first nonce.
    set_job(GENESIS, 32'd5, 32'd9, '1);
    chk("hit1_idle_busy", 256'(busy_v[0]), 256'(0));
    run_u1(-1, cyc);
    chk("hit1_found", 256'(found_v[0]), 256'(1));
    chk("hit1_nonce", 256'(fnonce_v[0]), 256'(5));
    chk("hit1_tried", 256'(tried_v[0]), 256'(1));
    chk("hit1_cycles", 256'(cyc), 256'(198));

    // Abort while idle is ignored; found holds until the next accepted start.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("found_held", 256'(found_v[0]), 256'(1));

    // Wrapping range with start and abort together: the abort is dropped.
    set_job(GENESIS, 32'hFFFFFFFE, 32'h00000001, '0);
    run_u1(0, cyc);
    chk("wrap_found", 256'(found_v[0]), 256'(0));
    chk("wrap_nonce", 256'(fnonce_v[0]), 256'(0));
    chk("wrap_tried", 256'(tried_v[0]), 256'(4));
    chk("wrap_cycles", 256'(cyc), 256'(591));

    // Abort during the third BLK2.
    set_job(GENESIS, 32'd0, 32'd999, '0);
    run_u1(350, cyc);
    chk("abort3_found", 256'(found_v[0]), 256'(0));
    chk("abort3_tried", 256'(tried_v[0]), 256'(3));
    chk("abort3_cycles", 256'(cyc), 256'(460));

    // Abort during MID acts at the first CMP.
    run_u1(10, cyc);
    chk("abortmid_tried", 256'(tried_v[0]), 256'(1));
    chk("abortmid_cycles", 256'(cyc), 256'(198));

    // Reset during the second nonce's DBL, then a clean genesis job.
    set_job(GENESIS, 32'h7C2BAC1A, 32'h7C2BAC1F, GEN_TGT);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (299) tick();
    chk("pre_rst_tried", 256'(tried_v[0]), 256'(1));
    rst_n = 1'b0;
    tick();
    tick();
    chk("mid_rst_busy", 256'(busy_v[0]), 256'(0));
    chk("mid_rst_done", 256'(done_v[0]), 256'(0));
    chk("mid_rst_tried", 256'(tried_v[0]), 256'(0));
    chk("mid_rst_found_u8", 256'(found_v[3]), 256'(0));
    chk("mid_rst_hash_u8", fhash_v[3], 256'(0));
    rst_n = 1'b1;
    tick();
    run_u1(-1, cyc);
    chk("post_rst_found", 256'(found_v[0]), 256'(1));
    chk("post_rst_nonce", 256'(fnonce_v[0]), 256'h7C2BAC1D);
    chk("post_rst_tried", 256'(tried_v[0]), 256'(4));
    chk("post_rst_hash", fhash_v[0], GEN_HASH);
    chk("post_rst_cycles", 256'(cyc), 256'(591));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
